rvfi_check_sequencer: RTL and testbench
=======================================

RVFI_CHECK_SEQUENCER -- requirements
Module: rvfi_check_sequencer

Interface
REQ-001 SHALL have parameter NRET, default 1: number of RVFI retirement channels (1..8).
REQ-002 SHALL have parameter XLEN, default 32: register and PC width.
REQ-003 SHALL have parameter SKIP, default 0: retirements ignored before the checked one.
REQ-004 SHALL have parameter DEPTH, default 20: cycles allowed in SKIP state before timeout (>=1).
REQ-005 SHALL have port clock  in  1  rising-edge clock.
REQ-006 SHALL have port reset  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port enable  in  1  level start/run request.
REQ-008 SHALL have port rvfi_valid  in  NRET  per-channel retirement valid.
REQ-009 SHALL have port rvfi_instruction  in  NRET*32  per-channel instruction word, channel c at [c*32 +: 32].
REQ-010 SHALL have port rvfi_pc_rdata  in  NRET*XLEN  per-channel PC, channel c at [c*XLEN +: XLEN].
REQ-011 SHALL have port rvfi_trap  in  NRET  per-channel trap flag.
REQ-012 SHALL have port rvfi_halt  in  NRET  per-channel halt flag.
REQ-013 SHALL have port check  out  1  one-cycle pulse; the downstream instruction checker evaluates the captured retirement.
REQ-014 SHALL have port check_chan  out  max(1,clog2(NRET))  captured channel index.
REQ-015 SHALL have port check_insn  out  32  captured instruction.
REQ-016 SHALL have port check_pc  out  XLEN  captured PC.
REQ-017 SHALL have port check_trap  out  1  captured trap flag.
REQ-018 SHALL have port busy  out  1  high in SKIP and CHECK.
REQ-019 SHALL have port done  out  1  high in DONE.
REQ-020 SHALL have port timeout  out  1  sticky; DONE reached without capture because cycle budget expired.
REQ-021 SHALL have port halted  out  1  sticky; DONE reached without capture because of a halt.
REQ-022 SHALL have port retire_cnt  out  16  retirements counted since entering SKIP, saturating at 16'hFFFF.

Function
REQ-023 SHALL implement states IDLE, SKIP, CHECK and DONE.
REQ-024 IDLE: enable=1 SHALL move to SKIP next cycle and clear cycle_cnt, retire_cnt, timeout, halted and captured fields.
REQ-025 SKIP: each cycle, cycle_cnt SHALL increment by 1 and retire_cnt SHALL increase by popcount(rvfi_valid), saturating.
REQ-026 SKIP: let rem = SKIP - retire_cnt. When popcount(rvfi_valid) > rem, the block SHALL capture the valid channel with 0-based ordinal rem, counted in ascending channel index among set valid bits, and move to CHECK.
REQ-027 Capture SHALL register that channel's index, instruction, pc_rdata and trap into check_chan/insn/pc/trap, visible in the CHECK cycle.
REQ-028 CHECK SHALL assert check=1 for exactly one cycle, then move unconditionally to DONE; captured fields SHALL hold until the next IDLE->SKIP.
REQ-029 SKIP: if no capture occurs and a valid channel has rvfi_halt=1, the block SHALL set halted=1 and move to DONE.
REQ-030 SKIP: if no capture and no halt occur and cycle_cnt==DEPTH-1, the block SHALL set timeout=1 and move to DONE.
REQ-031 Simultaneous events in one SKIP cycle SHALL resolve with priority capture > halt > timeout; a halting instruction that is itself selected SHALL be captured.
REQ-032 SKIP with enable=0 SHALL abort to IDLE next cycle with no check pulse; retire_cnt SHALL hold its value.
REQ-033 CHECK SHALL ignore enable.
REQ-034 DONE SHALL hold until enable=0, then move to IDLE; timeout, halted and captured fields SHALL persist into IDLE.
REQ-035 check SHALL be high only in CHECK; at most one pulse per IDLE->SKIP entry.
REQ-036 cycle_cnt SHALL be internal, 16 bits wide, and SHALL not wrap before DEPTH is reached.

Reset
REQ-037 reset=0 at a rising edge SHALL force IDLE and zero check, check_chan, check_insn, check_pc, check_trap, busy, done, timeout, halted and retire_cnt, from any state.
REQ-038 Reset asserted during CHECK SHALL suppress the check pulse on the following cycle.

Verification
REQ-039 Bench SHALL cover: NRET=1, SKIP=0, enable=1, valid=1 on SKIP cycle 2 with insn 32'h00500093 -> check=1 one cycle later, check_insn=32'h00500093, check_chan=0, done next cycle.
REQ-040 Bench SHALL cover: NRET=2, SKIP=2, valid=2'b11 then 2'b11 -> capture on second cycle, channel 0 (ordinal 0), retire_cnt=4.
REQ-041 Bench SHALL cover: NRET=4, SKIP=1, single cycle valid=4'b1010 -> capture channel 3.
REQ-042 Bench SHALL cover: DEPTH=5, no valid -> timeout=1, done=1 after 5 SKIP cycles, check never asserted.
REQ-043 Bench SHALL cover: SKIP=3, valid+halt on channel 0 at retire_cnt=0 -> halted=1, no check; with SKIP=0 the same input -> captured, halted=0.
REQ-044 Bench SHALL cover: reset=0 during CHECK -> no check pulse, all outputs zero next cycle; enable=0 in SKIP -> IDLE, no pulse.

Source files
------------

// File: rtl/rvfi_check_sequencer.sv
// Picks the retirement with global ordinal SKIP (counted across all channels
// since the run started) and hands it to the downstream instruction checker.

module rvfi_seq_lane (
  input  logic       valid,
  input  logic [3:0] ord_in,
  input  logic [3:0] rem,
  input  logic       rem_ok,
  output logic [3:0] ord_out,
  output logic       hit
);
  assign ord_out = ord_in + {3'b000, valid};
  assign hit     = valid && rem_ok && (ord_in == rem);
endmodule

module rvfi_check_sequencer #(
  parameter  int NRET  = 1,
  parameter  int XLEN  = 32,
  parameter  int SKIP  = 0,
  parameter  int DEPTH = 20,
  localparam int CW    = (NRET > 1) ? $clog2(NRET) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [NRET*32-1:0]   rvfi_instruction,
  input  logic [NRET*XLEN-1:0] rvfi_pc_rdata,
  input  logic [NRET-1:0]      rvfi_trap,
  input  logic [NRET-1:0]      rvfi_halt,
  output logic                 check,
  output logic [CW-1:0]        check_chan,
  output logic [31:0]          check_insn,
  output logic [XLEN-1:0]      check_pc,
  output logic                 check_trap,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic                 halted,
  output logic [15:0]          retire_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CHECK, S_DONE} state_t;

  state_t              state;
  logic [15:0]         cycle_cnt;
  logic [NRET:0][3:0]  ord;
  logic [NRET-1:0]     hit;
  logic [31:0]         rem;
  logic                rem_ok;
  logic [16:0]         rsum;
  logic [15:0]         retire_nxt;
  logic                capture, halt_any, last_cycle;
  logic [CW-1:0]       sel_chan;
  logic [31:0]         sel_insn;
  logic [XLEN-1:0]     sel_pc;
  logic                sel_trap;

  // Retirements still to skip this cycle; only meaningful while it fits in a channel ordinal.
  assign rem    = 32'(SKIP) - {16'b0, retire_cnt};
  assign rem_ok = ({16'b0, retire_cnt} <= 32'(SKIP)) && (rem < 32'(NRET));
  assign ord[0] = '0;

  // Each lane learns its ordinal among the set valid bits below it.
  for (genvar c = 0; c < NRET; c++) begin : g_lane
    rvfi_seq_lane u_lane (
      .valid  (rvfi_valid[c]),
      .ord_in (ord[c]),
      .rem    (rem[3:0]),
      .rem_ok (rem_ok),
      .ord_out(ord[c+1]),
      .hit    (hit[c])
    );
  end

  assign capture    = |hit;
  assign halt_any   = |(rvfi_valid & rvfi_halt);
  assign last_cycle = (cycle_cnt == 16'(DEPTH - 1));
  assign rsum       = {1'b0, retire_cnt} + 17'(ord[NRET]);
  assign retire_nxt = rsum[16] ? 16'hFFFF : rsum[15:0];

  always_comb begin
    sel_chan = '0;
    sel_insn = '0;
    sel_pc   = '0;
    sel_trap = 1'b0;
    for (int c = 0; c < NRET; c++) begin
      if (hit[c]) begin
        sel_chan = CW'(c);
        sel_insn = rvfi_instruction[c*32 +: 32];
        sel_pc   = rvfi_pc_rdata[c*XLEN +: XLEN];
        sel_trap = rvfi_trap[c];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      cycle_cnt  <= '0;
      check      <= 1'b0;
      check_chan <= '0;
      check_insn <= '0;
      check_pc   <= '0;
      check_trap <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      halted     <= 1'b0;
      retire_cnt <= '0;
    end else begin
      check <= 1'b0;
      case (state)
        S_IDLE: if (enable) begin
          state      <= S_SKIP;
          busy       <= 1'b1;
          cycle_cnt  <= '0;
          retire_cnt <= '0;
          timeout    <= 1'b0;
          halted     <= 1'b0;
          check_chan <= '0;
          check_insn <= '0;
          check_pc   <= '0;
          check_trap <= 1'b0;
        end
        S_SKIP: if (!enable) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end else begin
          if (cycle_cnt != 16'hFFFF) cycle_cnt <= cycle_cnt + 16'd1;
          retire_cnt <= retire_nxt;
          if (capture) begin
            state      <= S_CHECK;
            check      <= 1'b1;
            check_chan <= sel_chan;
            check_insn <= sel_insn;
            check_pc   <= sel_pc;
            check_trap <= sel_trap;
          end else if (halt_any) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            halted <= 1'b1;
          end else if (last_cycle) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        S_CHECK: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_DONE: if (!enable) begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Four differently parameterised sequencers share one stimulus bus; directed
// table rows, a hand-written reset/abort sequence and random traffic vs a model.

module tb_rvfi_check_sequencer;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset, enable;
  logic [7:0]   v, h, t;
  logic [255:0] insn_bus, pc_bus;

  logic        ck[4], tr[4], by[4], dn[4], to[4], ha[4];
  logic [31:0] ins[4], pcv[4];
  logic [15:0] rc[4];
  logic [0:0]  ch0, ch1, ch3;
  logic [1:0]  ch2;

  localparam int NR[4] = '{1, 2, 4, 1};
  localparam int SK[4] = '{0, 2, 1, 3};
  localparam int DP[4] = '{20, 20, 20, 5};

  rvfi_check_sequencer #(.NRET(1), .XLEN(32), .SKIP(0), .DEPTH(20)) u0 (
    .clock(clock), .reset(reset), .enable(enable), .rvfi_valid(v[0:0]),
    .rvfi_instruction(insn_bus[31:0]), .rvfi_pc_rdata(pc_bus[31:0]),
    .rvfi_trap(t[0:0]), .rvfi_halt(h[0:0]), .check(ck[0]), .check_chan(ch0),
    .check_insn(ins[0]), .check_pc(pcv[0]), .check_trap(tr[0]), .busy(by[0]),
    .done(dn[0]), .timeout(to[0]), .halted(ha[0]), .retire_cnt(rc[0]));

  rvfi_check_sequencer #(.NRET(2), .XLEN(32), .SKIP(2), .DEPTH(20)) u1 (
    .clock(clock), .reset(reset), .enable(enable), .rvfi_valid(v[1:0]),
    .rvfi_instruction(insn_bus[63:0]), .rvfi_pc_rdata(pc_bus[63:0]),
    .rvfi_trap(t[1:0]), .rvfi_halt(h[1:0]), .check(ck[1]), .check_chan(ch1),
    .check_insn(ins[1]), .check_pc(pcv[1]), .check_trap(tr[1]), .busy(by[1]),
    .done(dn[1]), .timeout(to[1]), .halted(ha[1]), .retire_cnt(rc[1]));

  rvfi_check_sequencer #(.NRET(4), .XLEN(32), .SKIP(1), .DEPTH(20)) u2 (
    .clock(clock), .reset(reset), .enable(enable), .rvfi_valid(v[3:0]),
    .rvfi_instruction(insn_bus[127:0]), .rvfi_pc_rdata(pc_bus[127:0]),
    .rvfi_trap(t[3:0]), .rvfi_halt(h[3:0]), .check(ck[2]), .check_chan(ch2),
    .check_insn(ins[2]), .check_pc(pcv[2]), .check_trap(tr[2]), .busy(by[2]),
    .done(dn[2]), .timeout(to[2]), .halted(ha[2]), .retire_cnt(rc[2]));

  rvfi_check_sequencer #(.NRET(1), .XLEN(32), .SKIP(3), .DEPTH(5)) u3 (
    .clock(clock), .reset(reset), .enable(enable), .rvfi_valid(v[0:0]),
    .rvfi_instruction(insn_bus[31:0]), .rvfi_pc_rdata(pc_bus[31:0]),
    .rvfi_trap(t[0:0]), .rvfi_halt(h[0:0]), .check(ck[3]), .check_chan(ch3),
    .check_insn(ins[3]), .check_pc(pcv[3]), .check_trap(tr[3]), .busy(by[3]),
    .done(dn[3]), .timeout(to[3]), .halted(ha[3]), .retire_cnt(rc[3]));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference: a run is a numbered stream of retirements; the one numbered SKIP is checked.
  localparam int P_IDLE = 0, P_SKIP = 1, P_CHECK = 2, P_DONE = 3;
  typedef struct packed {
    int          ph;
    int          cyc;
    int          ret;
    logic        to, ha, trap;
    logic [2:0]  ch;
    logic [31:0] insn, pc;
  } mdl_t;
  mdl_t m[4];

  task automatic mstep(int i);
    mdl_t s;
    int   k;
    bit   cap, hlt;
    s = m[i];
    if (!reset) s = '0;
    else case (s.ph)
      P_IDLE: if (enable) begin s = '0; s.ph = P_SKIP; end
      P_SKIP: if (!enable) s.ph = P_IDLE;
      else begin
        k = 0; cap = 0; hlt = 0;
        for (int c = 0; c < NR[i]; c++) begin
          if (v[c]) begin
            if (!cap && (s.ret + k == SK[i])) begin
              cap = 1; s.ch = 3'(c); s.trap = t[c];
              s.insn = insn_bus[c*32 +: 32]; s.pc = pc_bus[c*32 +: 32];
            end
            if (h[c]) hlt = 1;
            k++;
          end
        end
        s.ret = (s.ret + k > 65535) ? 65535 : s.ret + k;
        if (cap) s.ph = P_CHECK;
        else if (hlt) begin s.ha = 1; s.ph = P_DONE; end
        else if (s.cyc == DP[i] - 1) begin s.to = 1; s.ph = P_DONE; end
        s.cyc++;
      end
      P_CHECK: s.ph = P_DONE;
      default: if (!enable) s.ph = P_IDLE;
    endcase
    m[i] = s;
  endtask

  function automatic logic [2:0] chan_of(int i);
    case (i)
      0: return {2'b0, ch0};
      1: return {2'b0, ch1};
      2: return {1'b0, ch2};
      default: return {2'b0, ch3};
    endcase
  endfunction

  function automatic logic [88:0] act_vec(int i);
    return {ck[i], by[i], dn[i], to[i], ha[i], chan_of(i), ins[i], pcv[i], tr[i], rc[i]};
  endfunction

  function automatic logic [88:0] mdl_vec(int i);
    return {m[i].ph == P_CHECK, m[i].ph == P_SKIP || m[i].ph == P_CHECK, m[i].ph == P_DONE,
            m[i].to, m[i].ha, m[i].ch, m[i].insn, m[i].pc, m[i].trap, 16'(m[i].ret)};
  endfunction

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc%0d got %h exp %h", nm, cyc, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    for (int i = 0; i < 4; i++) mstep(i);
    @(negedge clock);
    cyc++;
    for (int i = 0; i < 4; i++) chk($sformatf("model_inst%0d", i), 128'(act_vec(i)), 128'(mdl_vec(i)));
  endtask

  typedef struct {
    bit rst, en; logic [7:0] v, h; int inst;
    bit ck, by, dn, to, ha; logic [2:0] ch; logic [15:0] rc; bit ci;
  } row_t;
  row_t tbl[$];

  function automatic void add(bit rst, bit en, logic [7:0] vv, logic [7:0] hh, int inst,
                              bit eck, bit eby, bit edn, bit eto, bit eha,
                              logic [2:0] ech, logic [15:0] erc, bit ci);
    tbl.push_back('{rst, en, vv, hh, inst, eck, eby, edn, eto, eha, ech, erc, ci});
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) m[i] = '0;
    reset = 0; enable = 0; v = 0; h = 0; t = 0;
    for (int c = 0; c < 8; c++) begin
      insn_bus[c*32 +: 32] = 32'h00500093 + 32'(c << 7);
      pc_bus[c*32 +: 32]   = 32'h8000_0000 + 32'(c * 4);
    end

    // single channel, SKIP=0: capture on second SKIP cycle, then halting-but-selected
    add(0,0,0,0,0, 0,0,0,0,0, 0,0,0);
    add(1,1,0,0,0, 0,1,0,0,0, 0,0,0);
    add(1,1,0,0,0, 0,1,0,0,0, 0,0,0);
    add(1,1,1,0,0, 1,1,0,0,0, 0,1,1);
    add(1,1,0,0,0, 0,0,1,0,0, 0,1,1);
    add(1,1,0,0,0, 0,0,1,0,0, 0,1,1);
    add(1,0,0,0,0, 0,0,0,0,0, 0,1,1);
    add(1,1,0,0,0, 0,1,0,0,0, 0,0,0);
    add(1,1,1,1,0, 1,1,0,0,0, 0,1,1);
    add(1,1,0,0,0, 0,0,1,0,0, 0,1,1);
    add(1,0,0,0,0, 0,0,0,0,0, 0,1,1);
    // NRET=2, SKIP=2
    add(0,0,0,0,1, 0,0,0,0,0, 0,0,0);
    add(1,1,0,0,1, 0,1,0,0,0, 0,0,0);
    add(1,1,3,0,1, 0,1,0,0,0, 0,2,0);
    add(1,1,3,0,1, 1,1,0,0,0, 0,4,1);
    add(1,1,0,0,1, 0,0,1,0,0, 0,4,1);
    // NRET=4, SKIP=1, sparse valid
    add(0,0,0,0,2, 0,0,0,0,0, 0,0,0);
    add(1,1,0,0,2, 0,1,0,0,0, 0,0,0);
    add(1,1,8'hA,0,2, 1,1,0,0,0, 3,2,1);
    add(1,1,0,0,2, 0,0,1,0,0, 3,2,1);
    // DEPTH=5 timeout, then SKIP=3 halt
    add(0,0,0,0,3, 0,0,0,0,0, 0,0,0);
    add(1,1,0,0,3, 0,1,0,0,0, 0,0,0);
    for (int n = 0; n < 4; n++) add(1,1,0,0,3, 0,1,0,0,0, 0,0,0);
    add(1,1,0,0,3, 0,0,1,1,0, 0,0,0);
    add(1,1,0,0,3, 0,0,1,1,0, 0,0,0);
    add(1,0,0,0,3, 0,0,0,1,0, 0,0,0);
    add(0,0,0,0,3, 0,0,0,0,0, 0,0,0);
    add(1,1,0,0,3, 0,1,0,0,0, 0,0,0);
    add(1,1,1,1,3, 0,0,1,0,1, 0,1,0);
    add(1,0,0,0,3, 0,0,0,0,1, 0,1,0);
    add(1,1,0,0,3, 0,1,0,0,0, 0,0,0);

    foreach (tbl[r]) begin
      reset = tbl[r].rst; enable = tbl[r].en; v = tbl[r].v; h = tbl[r].h;
      cycle();
      chk($sformatf("row%0d", r),
          128'({ck[tbl[r].inst], by[tbl[r].inst], dn[tbl[r].inst], to[tbl[r].inst],
                ha[tbl[r].inst], chan_of(tbl[r].inst), rc[tbl[r].inst]}),
          128'({tbl[r].ck, tbl[r].by, tbl[r].dn, tbl[r].to, tbl[r].ha, tbl[r].ch, tbl[r].rc}));
      if (tbl[r].ci) begin
        chk($sformatf("row%0d_insn", r), 128'(ins[tbl[r].inst]), 128'(insn_bus[tbl[r].ch*32 +: 32]));
        chk($sformatf("row%0d_pc", r), 128'(pcv[tbl[r].inst]), 128'(pc_bus[tbl[r].ch*32 +: 32]));
      end
    end

    // reset landing in CHECK kills the pulse; enable drop in SKIP aborts quietly
    reset = 0; enable = 0; v = 0; h = 0; cycle();
    reset = 1; enable = 1; cycle();
    v = 1; cycle();
    chk("pulse_before_rst", 128'(ck[0]), 128'(1));
    reset = 0; v = 0; cycle();
    chk("rst_in_check_zero", 128'({ck[0], by[0], dn[0], to[0], ha[0], ins[0], pcv[0], tr[0], rc[0]}), 128'(0));
    reset = 1; enable = 0; cycle();
    chk("no_pulse_after_rst", 128'(ck[0]), 128'(0));
    enable = 1; cycle();
    chk("abort_enter_skip", 128'(by[0]), 128'(1));
    v = 1; enable = 0; cycle();
    chk("abort_idle", 128'({ck[0], by[0], dn[0], rc[0]}), 128'(0));
    cycle();
    chk("abort_no_pulse", 128'(ck[0]), 128'(0));

    for (int n = 0; n < 800; n++) begin
      reset  = ($urandom_range(0, 59) != 0);
      enable = ($urandom_range(0, 9) != 0);
      v = 8'($urandom) & 8'($urandom);
      h = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h0;
      t = 8'($urandom);
      for (int c = 0; c < 8; c++) begin
        insn_bus[c*32 +: 32] = $urandom;
        pc_bus[c*32 +: 32]   = $urandom;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
